// File: rtl/spi_mem_ctrl_pkg.sv
// Shared command and state encodings for the SPI frame to memory sequencer.
package spi_mem_pkg;

  localparam int CTRL_WIDTH = 2;

  typedef enum logic [CTRL_WIDTH-1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    RD_WAIT,
    TX_HOLD
  } state_t;

endpackage

// File: rtl/spi_mem_ctrl_if.sv
// Frame, memory and status signals between the sequencer and its surroundings.
interface spi_mem_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  import spi_mem_pkg::*;

  logic                             ss_n;
  logic                             rx_valid;
  logic [DATA_WIDTH+CTRL_WIDTH-1:0] rx_data;
  logic                             tx_valid;
  logic [DATA_WIDTH-1:0]            tx_data;
  logic [ADDR_WIDTH-1:0]            mem_addr;
  logic [DATA_WIDTH-1:0]            mem_wdata;
  logic                             mem_we;
  logic                             mem_re;
  logic [DATA_WIDTH-1:0]            mem_rdata;
  logic                             err_seq;
  logic                             err_busy;

  modport master (
    input  ss_n, rx_valid, rx_data, mem_rdata,
    output tx_valid, tx_data, mem_addr, mem_wdata, mem_we, mem_re, err_seq, err_busy
  );

  modport slave (
    output ss_n, rx_valid, rx_data, mem_rdata,
    input  tx_valid, tx_data, mem_addr, mem_wdata, mem_we, mem_re, err_seq, err_busy
  );

endinterface

// File: rtl/spi_mem_ctrl.sv
// Decodes SPI slave frames into address latch, memory write and memory read
// operations, returning read data to the slave over the tx handshake.
module spi_mem_ctrl
  import spi_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int MEM_RD_LATENCY = 1,
  parameter bit AUTO_INC       = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_mem_ctrl_if.master bus
);

  localparam int CNT_WIDTH = 3;

  state_t                state;
  logic                  rx_valid_q;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  wr_addr_ok;
  logic                  rd_addr_ok;
  logic [CNT_WIDTH-1:0]  wait_cnt;
  cmd_t                  cmd;
  logic [DATA_WIDTH-1:0] payload;
  logic                  accept;

  assign cmd     = cmd_t'(bus.rx_data[DATA_WIDTH+CTRL_WIDTH-1:DATA_WIDTH]);
  assign payload = bus.rx_data[DATA_WIDTH-1:0];
  // Only a rising edge of rx_valid starts a frame; a held level never re-triggers.
  assign accept  = bus.rx_valid && !rx_valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      rx_valid_q    <= 1'b0;
      wr_addr       <= '0;
      rd_addr       <= '0;
      wr_addr_ok    <= 1'b0;
      rd_addr_ok    <= 1'b0;
      wait_cnt      <= '0;
      bus.tx_valid  <= 1'b0;
      bus.tx_data   <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_re    <= 1'b0;
      bus.err_seq   <= 1'b0;
      bus.err_busy  <= 1'b0;
    end else begin
      rx_valid_q   <= bus.rx_valid;
      bus.mem_we   <= 1'b0;
      bus.mem_re   <= 1'b0;
      bus.err_seq  <= 1'b0;
      bus.err_busy <= accept && (state != IDLE);

      case (state)
        IDLE: begin
          if (accept) begin
            case (cmd)
              CMD_WR_ADDR: begin
                wr_addr    <= payload[ADDR_WIDTH-1:0];
                wr_addr_ok <= 1'b1;
              end
              CMD_WR_DATA: begin
                if (wr_addr_ok) begin
                  state         <= WRITE;
                  bus.mem_we    <= 1'b1;
                  bus.mem_addr  <= wr_addr;
                  bus.mem_wdata <= payload;
                end else begin
                  bus.err_seq <= 1'b1;
                end
              end
              CMD_RD_ADDR: begin
                rd_addr    <= payload[ADDR_WIDTH-1:0];
                rd_addr_ok <= 1'b1;
              end
              CMD_RD_DATA: begin
                if (rd_addr_ok) begin
                  state        <= READ;
                  bus.mem_re   <= 1'b1;
                  bus.mem_addr <= rd_addr;
                end else begin
                  bus.err_seq <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        WRITE: begin
          if (AUTO_INC) wr_addr <= wr_addr + ADDR_WIDTH'(1);
          state <= IDLE;
        end
        READ: begin
          wait_cnt <= CNT_WIDTH'(MEM_RD_LATENCY);
          if (AUTO_INC) rd_addr <= rd_addr + ADDR_WIDTH'(1);
          state <= RD_WAIT;
        end
        // Deselect while waiting on memory abandons the read without presenting data.
        RD_WAIT: begin
          if (bus.ss_n) begin
            state <= IDLE;
          end else if (wait_cnt == CNT_WIDTH'(1)) begin
            bus.tx_data  <= bus.mem_rdata;
            bus.tx_valid <= 1'b1;
            state        <= TX_HOLD;
          end else begin
            wait_cnt <= wait_cnt - CNT_WIDTH'(1);
          end
        end
        TX_HOLD: begin
          if (bus.ss_n) begin
            bus.tx_valid <= 1'b0;
            bus.tx_data  <= '0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_mem_ctrl.md
Name: spi_mem_ctrl

Overview:
Command sequencer between the SPI slave frame interface and a single-port synchronous memory. It decodes each received 10-bit frame (2 control bits plus 8 data bits) into address latch, memory write or memory read operations. It returns read data to the slave through the tx_valid/tx_data handshake. It flags protocol misuse and frames that arrive while it is busy.

Parameters:
DATA_WIDTH, 8, frame payload and memory word width; equals the SPI slave FRAME_WIDTH.
ADDR_WIDTH, 8, memory address width; must be ≤ DATA_WIDTH.
MEM_RD_LATENCY, 1, cycles from mem_re to valid mem_rdata; legal range 1..4.
AUTO_INC, 0, if 1, wr_addr/rd_addr post-increment after each write/read (wraps modulo 2^ADDR_WIDTH).

Ports:
clk  in  1  clock
rst_n  in  1  reset
ss_n  in  1  SPI slave select, active-low, already synchronous to clk
rx_valid  in  1  slave frame-valid level; stays high until frame end
rx_data  in  DATA_WIDTH+2  frame; [DATA_WIDTH+1:DATA_WIDTH] = cmd, [DATA_WIDTH-1:0] = payload
tx_valid  out  1  read data available to slave
tx_data  out  DATA_WIDTH  read data to slave
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_we  out  1  write strobe, one-cycle pulse
mem_re  out  1  read strobe, one-cycle pulse
mem_rdata  in  DATA_WIDTH  memory read data
err_seq  out  1  one-cycle pulse, sequencing error
err_busy  out  1  one-cycle pulse, frame dropped while busy

Behaviour:
- Reset: rst_n, synchronous, active-low; clock clk. All outputs are 0. wr_addr = 0, rd_addr = 0, wr_addr_ok = 0, rd_addr_ok = 0, state = IDLE, rx_valid_q = 0.
- Frame accept: a frame is accepted only on a rx_valid rising edge, defined as rx_valid=1 and rx_valid_q=0. rx_valid_q is a registered copy of rx_valid, updated every cycle in every state. A held-high rx_valid never re-triggers.
- Commands:
  - 00 WR_ADDR: wr_addr ← payload[ADDR_WIDTH-1:0]; wr_addr_ok ← 1.
  - 01 WR_DATA: write payload to wr_addr.
  - 10 RD_ADDR: rd_addr ← payload; rd_addr_ok ← 1.
  - 11 RD_DATA: read memory at rd_addr, return the word; payload is ignored.
- States:
  - IDLE: accepts frames.
    - WR_ADDR and RD_ADDR complete in IDLE.
    - WR_DATA with wr_addr_ok=1 → WRITE.
    - RD_DATA with rd_addr_ok=1 → READ.
    - WR_DATA with wr_addr_ok=0, or RD_DATA with rd_addr_ok=0: no memory access, err_seq pulses next cycle, stay in IDLE.
  - WRITE (1 cycle): mem_we=1, mem_addr=wr_addr, mem_wdata=payload latched at accept. If AUTO_INC, wr_addr increments. Next state IDLE.
  - READ (1 cycle): mem_re=1, mem_addr=rd_addr; wait counter loaded with MEM_RD_LATENCY. If AUTO_INC, rd_addr increments. Next state RD_WAIT.
  - RD_WAIT: counter decrements each cycle. When it reaches 0, tx_data ← mem_rdata and tx_valid ← 1 → TX_HOLD.
    - If ss_n=1 in any RD_WAIT cycle: abort to IDLE, tx_valid stays 0, data is discarded.
  - TX_HOLD: tx_valid and tx_data held stable while ss_n=0. On ss_n=1: tx_valid ← 0, tx_data ← 0, next state IDLE.
- Latency:
  - Accept edge at cycle N → mem_we (or mem_re) high at N+1.
  - tx_valid high at N+2+MEM_RD_LATENCY.
- Frames accepted in any state other than IDLE are dropped: no state change, err_busy pulses next cycle.
- mem_addr and mem_wdata are don't-care when no strobe is asserted; they are held at their last value.
- mem_we and mem_re are never high together.
- Reset mid-operation: state → IDLE, all strobes and tx_valid drop next cycle, address-valid flags clear.
- Address wrap: with AUTO_INC, the increment past 2^ADDR_WIDTH-1 wraps to 0.

Decomposition:
- Package spi_mem_pkg:
  - cmd_t enum: CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
  - state_t enum: IDLE, WRITE, READ, RD_WAIT, TX_HOLD.
  - CTRL_WIDTH=2.
- Single flat module; no sub-module. Edge detection and the latency counter are inline.

Test Plan:
- Write path: frame 0x0_A5 (WR_ADDR, 0xA5) then 0x1_3C → one cycle with mem_we=1, mem_addr=0xA5, mem_wdata=0x3C, at accept+1.
- Read path, MEM_RD_LATENCY=2: RD_ADDR 0x10, RD_DATA, memory holds 0x77 at 0x10 → mem_re at accept+1; tx_valid=1, tx_data=0x77 at accept+4; held until ss_n=1, then tx_valid=0.
- Sequencing error after reset: WR_DATA 0x55 with no prior WR_ADDR → mem_we stays 0, err_seq is a single pulse. Same check for RD_DATA with no prior RD_ADDR.
- Busy drop: new rx_valid edge while in RD_WAIT → err_busy pulse, read still completes; rx_valid held high for 20 cycles gives exactly one accept.
- AUTO_INC=1: WR_ADDR 0xFF, then three WR_DATA frames → writes to 0xFF, 0x00, 0x01.
- Aborts: ss_n=1 during RD_WAIT → tx_valid never asserts, state returns to IDLE. rst_n=0 while in TX_HOLD → tx_valid=0 next cycle, a subsequent WR_DATA raises err_seq.
